// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and FSM state type for the fetch unit
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, flush-to-NOP and hold
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_d, pc_q;
  logic        valid_d, valid_q;

  // Flush replaces the instruction with a bubble but keeps the PC fields.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = load_instr;
      pc_d    = load_pc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with one-entry skid buffer and branch redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4_id,
  output logic        id_valid,
  output logic        fetch_misalign
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_f_d, pc_f_q;
  logic [31:0]  skid_instr_d, skid_instr_q;
  logic [31:0]  skid_pc_d, skid_pc_q;
  logic         ifid_load, ifid_flush;
  logic [31:0]  ifid_instr, ifid_pc;
  logic         redirect;
  logic [31:0]  target;

  assign redirect = branch_taken & id_valid;
  assign target   = pc_id + imm_ext;

  // Redirect outranks everything; in-flight data and the skid entry are dropped.
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr   = imem_rdata;
    ifid_pc      = pc_f_q;
    if (redirect) begin
      pc_f_d       = {target[31:2], 2'b00};
      ifid_flush   = 1'b1;
      skid_instr_d = NOP_INSTR;
      skid_pc_d    = 32'h0;
      state_d      = FETCH_REQ;
    end else begin
      case (state_q)
        FETCH_IDLE: state_d = FETCH_REQ;
        FETCH_REQ: begin
          if (imem_valid) begin
            pc_f_d = pc_f_q + 32'd4;
            if (!stall) begin
              ifid_load = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_f_q;
              state_d      = FETCH_HOLD;
            end
          end else if (!stall) begin
            ifid_flush = 1'b1;
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            ifid_load  = 1'b1;
            ifid_instr = skid_instr_q;
            ifid_pc    = skid_pc_q;
            state_d    = FETCH_REQ;
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_IDLE;
      pc_f_q       <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .load_instr (ifid_instr),
    .load_pc    (ifid_pc),
    .instr      (instr_id),
    .pc         (pc_id),
    .valid      (id_valid)
  );

  assign imem_req       = (state_q == FETCH_REQ);
  assign imem_addr      = pc_f_q;
  assign pc_plus4_id    = pc_id + 32'd4;
  assign fetch_misalign = redirect & ~reset & (target[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a queue-based model
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] imm_ext;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic [31:0] pc_plus4_id;
  logic        id_valid;
  logic        fetch_misalign;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .imm_ext        (imm_ext),
    .instr_id       (instr_id),
    .pc_id          (pc_id),
    .pc_plus4_id    (pc_plus4_id),
    .id_valid       (id_valid),
    .fetch_misalign (fetch_misalign)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: fetch pointer, decode slot and a queue standing in for the skid entry.
  logic [31:0] m_pc_f;
  logic [31:0] m_instr;
  logic [31:0] m_pc_id;
  logic        m_valid;
  logic        m_idle;
  logic [63:0] m_skid[$];
  logic        last_mis;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [31:0] rd,
                            input logic s, input logic b, input logic [31:0] im);
    logic [31:0] tgt;
    tgt = m_pc_id + im;
    if (r) begin
      m_pc_f = 32'h0; m_idle = 1'b1; m_instr = NOP; m_pc_id = 32'h0; m_valid = 1'b0;
      m_skid.delete();
    end else if (b && m_valid) begin
      m_pc_f = tgt & 32'hFFFF_FFFC; m_instr = NOP; m_valid = 1'b0; m_idle = 1'b0;
      m_skid.delete();
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_skid.size() > 0) begin
      if (!s) begin
        m_instr = m_skid[0][31:0]; m_pc_id = m_skid[0][63:32]; m_valid = 1'b1;
        m_skid.delete();
      end
    end else if (v) begin
      if (!s) begin
        m_instr = rd; m_pc_id = m_pc_f; m_valid = 1'b1;
      end else begin
        m_skid.push_back({m_pc_f, rd});
      end
      m_pc_f = m_pc_f + 32'd4;
    end else if (!s) begin
      m_instr = NOP; m_valid = 1'b0;
    end
  endtask

  // One clock: drive at negedge, compare everything, then advance the model past the edge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] rd,
                     input logic s, input logic b, input logic [31:0] im);
    logic [31:0] tgt;
    @(negedge clk);
    reset = r; imem_valid = v; imem_rdata = rd; stall = s; branch_taken = b; imm_ext = im;
    #1;
    tgt = m_pc_id + im;
    last_mis = fetch_misalign;
    chk_eq("imem_req", {31'b0, imem_req}, {31'b0, !m_idle && m_skid.size() == 0});
    chk_eq("imem_addr", imem_addr, m_pc_f);
    chk_eq("instr_id", instr_id, m_instr);
    chk_eq("pc_id", pc_id, m_pc_id);
    chk_eq("pc_plus4_id", pc_plus4_id, m_pc_id + 32'd4);
    chk_eq("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
    chk_eq("fetch_misalign", {31'b0, fetch_misalign},
           {31'b0, !r && b && m_valid && (tgt[1:0] != 2'b00)});
    @(posedge clk);
    #1;
    model_step(r, v, rd, s, b, im);
  endtask

  task automatic redirect_to(input logic [31:0] t);
    cyc(0, 1, 32'hDEAD_0000, 0, 1, t - m_pc_id);
    cyc(0, 1, m_pc_f, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] im;
    logic [31:0] exp_addr;
    reset = 1'b1; imem_valid = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    branch_taken = 1'b0; imm_ext = 32'h0;
    m_pc_f = 32'h0; m_idle = 1'b1; m_instr = NOP; m_pc_id = 32'h0; m_valid = 1'b0;
    last_mis = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_instr", instr_id, NOP);
    chk_eq("rst_pc_plus4", pc_plus4_id, 32'h4);
    chk_eq("rst_req", {31'b0, imem_req}, 32'h0);

    // streaming fetch with rdata equal to address
    cyc(0, 1, m_pc_f, 0, 0, 0);
    cyc(0, 1, m_pc_f, 0, 0, 0);
    chk_eq("stream_pc0", pc_id, 32'h0);
    chk_eq("stream_v0", {31'b0, id_valid}, 32'h1);
    cyc(0, 1, m_pc_f, 0, 0, 0);
    chk_eq("stream_pc4", pc_id, 32'h4);
    cyc(0, 1, m_pc_f, 0, 0, 0);
    chk_eq("stream_pc8", pc_id, 32'h8);
    chk_eq("stream_instr8", instr_id, 32'h8);

    // three stall cycles with data returning, then release
    for (int i = 0; i < 3; i++) cyc(0, 1, m_pc_f, 1, 0, 0);
    chk_eq("stall_frozen", pc_id, 32'h8);
    chk_eq("stall_addr", imem_addr, 32'h10);
    cyc(0, 0, 32'h0, 0, 0, 0);
    chk_eq("skid_instr", instr_id, 32'hC);
    chk_eq("skid_pc", pc_id, 32'hC);
    cyc(0, 1, m_pc_f, 0, 0, 0);
    chk_eq("after_skid", instr_id, 32'h10);

    // backward branch
    redirect_to(32'h100);
    chk_eq("at_100", pc_id, 32'h100);
    cyc(0, 1, 32'hBAD0_BAD0, 0, 1, 32'hFFFF_FFF0);
    chk_eq("br_addr", imem_addr, 32'h0F0);
    chk_eq("br_instr", instr_id, NOP);
    chk_eq("br_valid", {31'b0, id_valid}, 32'h0);

    // misaligned target
    cyc(0, 1, m_pc_f, 0, 0, 0);
    redirect_to(32'h200);
    cyc(0, 0, 32'h0, 0, 1, 32'h6);
    chk_eq("mis_pulse", {31'b0, last_mis}, 32'h1);
    chk_eq("mis_addr", imem_addr, 32'h204);
    cyc(0, 0, 32'h0, 0, 0, 0);
    chk_eq("mis_clear", {31'b0, last_mis}, 32'h0);

    // redirect wins over stall, imem_valid and HOLD
    cyc(0, 1, m_pc_f, 0, 0, 0);
    cyc(0, 1, m_pc_f, 1, 0, 0);
    cyc(0, 1, m_pc_f, 1, 0, 0);
    exp_addr = (m_pc_id + 32'h40) & 32'hFFFF_FFFC;
    cyc(0, 1, 32'h5555_5555, 1, 1, 32'h40);
    chk_eq("hold_br_req", {31'b0, imem_req}, 32'h1);
    chk_eq("hold_br_addr", imem_addr, exp_addr);
    chk_eq("hold_br_valid", {31'b0, id_valid}, 32'h0);
    cyc(0, 0, 32'h0, 0, 0, 0);
    chk_eq("skid_dropped", instr_id, NOP);

    // PC wrap at 32 bits
    cyc(0, 1, m_pc_f, 0, 0, 0);
    redirect_to(32'hFFFF_FFFC);
    chk_eq("wrap_plus4", pc_plus4_id, 32'h0);
    chk_eq("wrap_addr", imem_addr, 32'h0);

    // reset in HOLD with skid full, everything else asserted
    cyc(0, 1, m_pc_f, 0, 0, 0);
    cyc(0, 1, m_pc_f, 1, 0, 0);
    cyc(1, 1, 32'h7777_7777, 1, 1, 32'h4);
    chk_eq("rh_instr", instr_id, NOP);
    chk_eq("rh_pc", pc_id, 32'h0);
    chk_eq("rh_plus4", pc_plus4_id, 32'h4);
    chk_eq("rh_valid", {31'b0, id_valid}, 32'h0);
    chk_eq("rh_req", {31'b0, imem_req}, 32'h0);
    chk_eq("rh_mis", {31'b0, fetch_misalign}, 32'h0);
    cyc(0, 1, 32'h9999_9999, 0, 0, 0);
    chk_eq("rh_req_after_idle", {31'b0, imem_req}, 32'h1);
    chk_eq("rh_addr_after_idle", imem_addr, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      im = $urandom_range(0, 255);
      im = im - 32'd128;
      if ($urandom_range(0, 3) != 0) im[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) im = $urandom;
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 6, $urandom,
          $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, im);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address (pc_f).
REQ-007 imem_rdata  input  32  returned instruction word.
REQ-008 imem_valid  input  1  imem_rdata valid for current imem_addr.
REQ-009 stall  input  1  decode stage cannot accept a new instruction.
REQ-010 branch_taken  input  1  instruction in ID is a taken branch.
REQ-011 imm_ext  input  32  sign-extended B-type offset for instruction in ID.
REQ-012 instr_id  output  32  IF/ID instruction register, feeds immediate extension and decode.
REQ-013 pc_id  output  32  PC of instr_id.
REQ-014 pc_plus4_id  output  32  pc_id + 4.
REQ-015 id_valid  output  1  instr_id holds a real instruction.
REQ-016 fetch_misalign  output  1  one-cycle pulse: branch target had bits[1:0] != 0.

Function
REQ-017 FSM states: IDLE, REQ, HOLD.
REQ-018 IDLE: imem_req=0; unconditionally -> REQ next cycle.
REQ-019 REQ: imem_req=1, imem_addr=pc_f, address stable until imem_valid or redirect.
REQ-020 REQ, imem_valid=1, stall=0: instr_id<=imem_rdata, pc_id<=pc_f, id_valid<=1, pc_f<=pc_f+4, stay REQ.
REQ-021 REQ, imem_valid=1, stall=1: imem_rdata and pc_f captured in one-entry skid buffer, pc_f<=pc_f+4, IF/ID held, -> HOLD.
REQ-022 REQ, imem_valid=0, stall=0: id_valid<=0, instr_id<=NOP_INSTR, IF/ID PC fields held.
REQ-023 Any state, stall=1 and no redirect: IF/ID registers unchanged.
REQ-024 HOLD: imem_req=0; on stall=0 skid contents move to IF/ID with id_valid<=1, -> REQ.
REQ-025 Redirect: branch_taken=1 with id_valid=1; target = pc_id + imm_ext, modulo 2^32.
REQ-026 Redirect priority over stall, imem_valid and HOLD: pc_f<=target with bits[1:0] cleared, instr_id<=NOP_INSTR, id_valid<=0, skid cleared, -> REQ.
REQ-027 Redirect: any imem_rdata returned the same cycle is discarded.
REQ-028 Redirect: imem address change aborts prior request; no outstanding state kept.
REQ-029 branch_taken with id_valid=0: ignored.
REQ-030 fetch_misalign=1 for exactly the redirect cycle when target[1:0] != 0.
REQ-031 pc_f+4 and pc_plus4_id wrap at 32 bits (32'hFFFF_FFFC + 4 = 0).
REQ-032 Fetch latency: instruction appears on instr_id the cycle after imem_valid when not stalled.

Reset
REQ-033 Reset values: pc_f=RESET_PC, state=IDLE, instr_id=NOP_INSTR, pc_id=0, pc_plus4_id=4, id_valid=0, imem_req=0, fetch_misalign=0, skid empty.
REQ-034 Reset overrides redirect, stall and imem_valid in the same cycle.
REQ-035 Reset mid-HOLD or mid-REQ discards skid and pending fetch.

Structure
REQ-036 Shared package holds RESET_PC default, NOP_INSTR, and the fetch FSM state enum.
REQ-037 One sub-module: if_id_reg (IF/ID register with load, flush-to-NOP, hold).
REQ-038 Target adder and PC incrementer inline, no separate module.

Verification
REQ-039 Reset released, imem_valid=1 every cycle with rdata=addr -> pc_id 0,4,8 on consecutive cycles, id_valid=1 from the third cycle.
REQ-040 stall=1 for 3 cycles while imem_valid=1 -> IF/ID frozen, one word in skid; after release, next instr_id = word at frozen pc_f, no drop or duplicate.
REQ-041 pc_id=32'h100, imm_ext=32'hFFFF_FFF0, branch_taken=1 -> next imem_addr=32'h0F0, instr_id=NOP_INSTR, id_valid=0.
REQ-042 branch_taken, stall and imem_valid all 1 while in HOLD -> redirect wins, skid cleared, state REQ.
REQ-043 pc_id=32'h200, imm_ext=32'h6 -> fetch_misalign pulses 1 cycle, imem_addr=32'h204.
REQ-044 reset asserted in HOLD with skid full -> next cycle outputs equal REQ-033 values, imem_addr=RESET_PC after IDLE.
